// File: rtl/vga_pattern_gen_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pkg;

    // Width of the pixel x/y coordinate counters
    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        LOCKED     = 1'b1
    } state_t;

    // {r,g,b} on/off flags of the eight colour bars, left to right:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_TABLE [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Bundle between the timing controller / DAC side and the pattern generator.
// master: drives the sync/active/mode stream and receives the pixel outputs.
// slave:  the pattern generator itself.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4
);
    import vga_pkg::*;

    logic               h_sync;
    logic               v_sync;
    logic               active;
    mode_t              mode;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_de;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic [15:0]        frame_cnt;

    modport master (
        output h_sync, v_sync, active, mode,
        input  vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_cnt
    );

    modport slave (
        input  h_sync, v_sync, active, mode,
        output vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_cnt
    );

endinterface

// File: rtl/vga_pattern_gen_lut.sv
// Combinational pattern colour lookup: mode + pixel coordinate -> packed {r,g,b}.
module vga_pattern_lut
    import vga_pkg::*;
#(
    parameter int                   COLOR_W   = 4,
    parameter int                   CHK_LOG2  = 5,
    parameter logic [3*COLOR_W-1:0] SOLID_RGB = {3*COLOR_W{1'b1}}
) (
    input  mode_t                mode,
    input  logic                 de,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [2:0]           bar_idx,
    output logic [3*COLOR_W-1:0] rgb
);

    logic [COLOR_W-1:0] grad_r;
    logic [COLOR_W-1:0] grad_g;
    logic [2:0]         bar_flags;
    logic               unused_coord_bits;

    assign grad_r            = x[COLOR_W+2:3];
    assign grad_g            = y[COLOR_W+2:3];
    assign bar_flags         = BAR_TABLE[bar_idx];
    assign unused_coord_bits = ^{x, y};

    // Pick the pattern colour for the pixel; blanked pixels are forced black
    always_comb begin
        rgb = '0;
        if (de) begin
            case (mode)
                MODE_SOLID: rgb = SOLID_RGB;
                MODE_BARS:  rgb = {{COLOR_W{bar_flags[2]}},
                                   {COLOR_W{bar_flags[1]}},
                                   {COLOR_W{bar_flags[0]}}};
                MODE_CHECK: rgb = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? {3*COLOR_W{1'b1}}
                                                              : {3*COLOR_W{1'b0}};
                MODE_GRAD:  rgb = {grad_r, grad_g, grad_r ^ grad_g};
                default:    rgb = '0;
            endcase
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: rebuilds x/y from the timing controller's
// sync/active stream and emits a 2-cycle pipelined pattern with delayed syncs.
// H_ACTIVE must be a multiple of 8 so the eight bars tile the line exactly.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int                   COLOR_W   = 4,
    parameter int                   H_ACTIVE  = 640,
    parameter int                   CHK_LOG2  = 5,
    parameter logic [3*COLOR_W-1:0] SOLID_RGB = {3*COLOR_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    vga_pattern_gen_if.slave bus
);

    localparam int                 BAR_W     = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] BAR_LAST  = COORD_W'(BAR_W - 1);
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    state_t               state;
    state_t               state_next;
    logic                 locked;
    logic                 v_sync_q;
    logic                 active_q;
    logic                 frame_start;
    logic                 line_end;
    mode_t                mode_l;
    logic [15:0]          frame_cnt;
    logic [COORD_W-1:0]   x_cnt;
    logic [COORD_W-1:0]   y_cnt;
    logic [COORD_W-1:0]   bar_px;
    logic [2:0]           bar_idx;

    logic [COORD_W-1:0]   x_s1;
    logic [COORD_W-1:0]   y_s1;
    logic [2:0]           bar_idx_s1;
    logic                 de_s1;
    logic                 hs_s1;
    logic                 vs_s1;
    logic [3*COLOR_W-1:0] rgb_s1;

    logic [3*COLOR_W-1:0] rgb_s2;
    logic                 de_s2;
    logic                 hs_s2;
    logic                 vs_s2;

    assign frame_start = v_sync_q & ~bus.v_sync;
    assign line_end    = active_q & ~bus.active;

    // One-cycle history of v_sync and active for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            v_sync_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            v_sync_q <= bus.v_sync;
            active_q <= bus.active;
        end
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_FRAME;
        else     state <= state_next;
    end

    // Lock onto the first frame start; only reset drops the lock again
    always_comb begin
        state_next = state;
        locked     = 1'b0;
        case (state)
            WAIT_FRAME: if (frame_start) state_next = LOCKED;
            LOCKED:     locked = 1'b1;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    // Frame counter and mode latch, both updated only at frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_l    <= MODE_SOLID;
            frame_cnt <= '0;
        end else if (frame_start) begin
            mode_l    <= bus.mode;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Horizontal position plus bar position, cleared outside the visible area
    always_ff @(posedge clk) begin
        if (rst || frame_start || !bus.active) begin
            x_cnt   <= '0;
            bar_px  <= '0;
            bar_idx <= '0;
        end else begin
            x_cnt <= x_cnt + COORD_W'(1);
            if (bar_px == BAR_LAST) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + COORD_W'(1);
            end
        end
    end

    // Line counter: frame start wins over a coincident line end
    always_ff @(posedge clk) begin
        if (rst || frame_start) y_cnt <= '0;
        else if (line_end && y_cnt != COORD_MAX) y_cnt <= y_cnt + COORD_W'(1);
    end

    // Stage 1: capture the coordinates and syncs belonging to this input cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            x_s1       <= '0;
            y_s1       <= '0;
            bar_idx_s1 <= '0;
            de_s1      <= 1'b0;
            hs_s1      <= 1'b1;
            vs_s1      <= 1'b1;
        end else begin
            x_s1       <= x_cnt;
            y_s1       <= y_cnt;
            bar_idx_s1 <= bar_idx;
            de_s1      <= bus.active & locked;
            hs_s1      <= bus.h_sync;
            vs_s1      <= bus.v_sync;
        end
    end

    vga_pattern_lut #(
        .COLOR_W   (COLOR_W),
        .CHK_LOG2  (CHK_LOG2),
        .SOLID_RGB (SOLID_RGB)
    ) u_lut (
        .mode    (mode_l),
        .de      (de_s1),
        .x       (x_s1),
        .y       (y_s1),
        .bar_idx (bar_idx_s1),
        .rgb     (rgb_s1)
    );

    // Stage 2: output registers toward the DAC
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s2 <= '0;
            de_s2  <= 1'b0;
            hs_s2  <= 1'b1;
            vs_s2  <= 1'b1;
        end else begin
            rgb_s2 <= rgb_s1;
            de_s2  <= de_s1;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
        end
    end

    assign bus.vga_hs    = hs_s2;
    assign bus.vga_vs    = vs_s2;
    assign bus.vga_de    = de_s2;
    assign bus.vga_r     = rgb_s2[3*COLOR_W-1 -: COLOR_W];
    assign bus.vga_g     = rgb_s2[2*COLOR_W-1 -: COLOR_W];
    assign bus.vga_b     = rgb_s2[COLOR_W-1:0];
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed testbench for vga_pattern_gen: a table of pixels with hand-computed
// colours plus sequences for locking, mode switching, frame count and reset.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    localparam int BLANK = 12;

    typedef struct {
        string       name;
        mode_t       mode;
        int          lines;
        int          act_len;
        int          cap_line;
        int          x;
        logic [12:0] exp_px;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    vga_pattern_gen_if #(.COLOR_W(4)) bus ();

    vga_pattern_gen #(
        .COLOR_W   (4),
        .H_ACTIVE  (640),
        .CHK_LOG2  (5),
        .SOLID_RGB (12'hFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tag_d1 = -1;
    int          tag_d2 = -1;
    logic        hs_d1 = 1'b1;
    logic        hs_d2 = 1'b1;
    logic        vs_d1 = 1'b1;
    logic        vs_d2 = 1'b1;
    logic        sync_chk_en = 1'b0;
    int          sync_err = 0;
    logic        pre_de;
    logic [12:0] cap_px [0:639];
    vec_t        vecs [$];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One pixel clock: sample outputs for the input driven two ticks ago, then drive
    task automatic applyStimulus(input logic hs, input logic vs, input logic act, input int tag);
        @(negedge clk);
        if (tag_d2 >= 0) cap_px[tag_d2] = {bus.vga_de, bus.vga_r, bus.vga_g, bus.vga_b};
        if (tag_d1 == 0) pre_de = bus.vga_de;
        if (sync_chk_en && (bus.vga_hs !== hs_d2 || bus.vga_vs !== vs_d2)) sync_err++;
        tag_d2 = tag_d1;
        tag_d1 = tag;
        hs_d2  = hs_d1;
        hs_d1  = hs;
        vs_d2  = vs_d1;
        vs_d1  = vs;
        bus.h_sync = hs;
        bus.v_sync = vs;
        bus.active = act;
    endtask

    task automatic blank_seg(input logic vs);
        for (int i = 0; i < BLANK; i++) applyStimulus(!(i >= 4 && i < 8), vs, 1'b0, -1);
    endtask

    task automatic run_lines(input int n, input int act_len, input int cap);
        for (int l = 0; l < n; l++) begin
            for (int x = 0; x < act_len; x++) applyStimulus(1'b1, 1'b1, 1'b1, (l == cap) ? x : -1);
            blank_seg(1'b1);
        end
    endtask

    task automatic frame_head();
        blank_seg(1'b0);
        blank_seg(1'b0);
        blank_seg(1'b1);
        blank_seg(1'b1);
    endtask

    task automatic frame_tail();
        blank_seg(1'b1);
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 640; i++) cap_px[i] = 'x;
    endtask

    task automatic count_lit(input int lo, input int hi, output int n);
        n = 0;
        for (int i = lo; i <= hi; i++) if (cap_px[i] !== 13'h0) n++;
    endtask

    task automatic add_vec(input string name, input mode_t mode, input int lines, input int act_len,
                           input int cap_line, input int x, input logic [12:0] exp_px);
        vec_t v;
        v.name = name; v.mode = mode; v.lines = lines; v.act_len = act_len;
        v.cap_line = cap_line; v.x = x; v.exp_px = exp_px;
        vecs.push_back(v);
    endtask

    initial begin
        int n;

        // expected pixel = {de, r, g, b}
        add_vec("bar_x0",       MODE_BARS,    1, 640,   0,   0, 13'h1FFF);
        add_vec("bar_x79",      MODE_BARS,    1, 640,   0,  79, 13'h1FFF);
        add_vec("bar_x80",      MODE_BARS,    1, 640,   0,  80, 13'h1FF0);
        add_vec("bar_x160",     MODE_BARS,    1, 640,   0, 160, 13'h10FF);
        add_vec("bar_x240",     MODE_BARS,    1, 640,   0, 240, 13'h10F0);
        add_vec("bar_x320",     MODE_BARS,    1, 640,   0, 320, 13'h1F0F);
        add_vec("bar_x400",     MODE_BARS,    1, 640,   0, 400, 13'h1F00);
        add_vec("bar_x480",     MODE_BARS,    1, 640,   0, 480, 13'h100F);
        add_vec("bar_x560",     MODE_BARS,    1, 640,   0, 560, 13'h1000);
        add_vec("bar_x639",     MODE_BARS,    1, 640,   0, 639, 13'h1000);
        add_vec("chk_x0_y0",    MODE_CHECK,   1,  64,   0,   0, 13'h1000);
        add_vec("chk_x32_y0",   MODE_CHECK,   1,  64,   0,  32, 13'h1FFF);
        add_vec("chk_x32_y32",  MODE_CHECK,  33,  64,  32,  32, 13'h1000);
        add_vec("chk_x0_y32",   MODE_CHECK,  33,  64,  32,   0, 13'h1FFF);
        add_vec("grad_x0_y479", MODE_GRAD,  480,  16, 479,   0, 13'h10BB);
        add_vec("grad_x8_y479", MODE_GRAD,  480,  16, 479,   8, 13'h11BA);
        add_vec("grad_x8_y0",   MODE_GRAD,    1,  16,   0,   8, 13'h1101);
        add_vec("solid_x5",     MODE_SOLID,   1,  16,   0,   5, 13'h1FFF);

        rst        = 1'b1;
        bus.h_sync = 1'b1;
        bus.v_sync = 1'b1;
        bus.active = 1'b0;
        bus.mode   = MODE_SOLID;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, -1);
        checkOutput("rst_hs",        32'(bus.vga_hs), 32'd1);
        checkOutput("rst_vs",        32'(bus.vga_vs), 32'd1);
        checkOutput("rst_de",        32'(bus.vga_de), 32'd0);
        checkOutput("rst_rgb",       32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        checkOutput("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst         = 1'b0;
        sync_chk_en = 1'b1;

        // No v_sync falling edge yet: the output must stay blank
        bus.mode = MODE_BARS;
        clear_cap();
        run_lines(2, 64, 1);
        count_lit(0, 63, n);
        checkOutput("no_lock_blank", 32'(n), 32'd0);

        foreach (vecs[i]) begin
            bus.mode = vecs[i].mode;
            clear_cap();
            pre_de = 1'b1;
            frame_head();
            run_lines(vecs[i].lines, vecs[i].act_len, vecs[i].cap_line);
            frame_tail();
            checkOutput(vecs[i].name, 32'(cap_px[vecs[i].x]), 32'(vecs[i].exp_px));
            checkOutput({vecs[i].name, "_lead"}, 32'(pre_de), 32'd0);
        end

        // Mode change mid-frame only takes effect at the next frame start
        bus.mode = MODE_SOLID;
        frame_head();
        run_lines(2, 16, -1);
        bus.mode = MODE_GRAD;
        clear_cap();
        run_lines(2, 16, 1);
        checkOutput("switch_holds", 32'(cap_px[8]), 32'h1FFF);
        frame_tail();
        clear_cap();
        frame_head();
        run_lines(1, 16, 0);
        frame_tail();
        checkOutput("switch_applies", 32'(cap_px[8]), 32'h1101);

        // Frame counter after reset and three frames
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, -1);
        rst = 1'b0;
        bus.mode = MODE_SOLID;
        repeat (3) begin
            frame_head();
            run_lines(2, 16, -1);
            frame_tail();
        end
        checkOutput("frame_cnt_3", 32'(bus.frame_cnt), 32'd3);

        // One-cycle reset in the middle of a visible line
        bus.mode = MODE_BARS;
        frame_head();
        run_lines(1, 640, -1);
        for (int x = 0; x < 100; x++) applyStimulus(1'b1, 1'b1, 1'b1, -1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, -1);
        checkOutput("midrst_de",        32'(bus.vga_de), 32'd0);
        checkOutput("midrst_rgb",       32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        checkOutput("midrst_hs",        32'(bus.vga_hs), 32'd1);
        checkOutput("midrst_vs",        32'(bus.vga_vs), 32'd1);
        checkOutput("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst = 1'b0;
        clear_cap();
        for (int x = 101; x < 640; x++) applyStimulus(1'b1, 1'b1, 1'b1, x);
        blank_seg(1'b1);
        count_lit(101, 639, n);
        checkOutput("midrst_blank", 32'(n), 32'd0);
        frame_tail();
        bus.mode = MODE_GRAD;
        clear_cap();
        frame_head();
        run_lines(1, 16, 0);
        frame_tail();
        checkOutput("relock_x0_y0",  32'(cap_px[0]), 32'h1000);
        checkOutput("relock_x8_y0",  32'(cap_px[8]), 32'h1101);
        checkOutput("relock_frames", 32'(bus.frame_cnt), 32'd1);

        checkOutput("sync_delay", 32'(sync_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream stage of the VGA sync/timing controller. Consumes its h_sync, v_sync and active outputs.
- Derives the pixel x/y coordinates from those signals. Generates a selectable test pattern as RGB.
- Drives pixel-aligned, pipeline-delayed sync, data-enable and colour outputs toward the DAC/pin stage.
- Needs no knowledge of porch/pulse timing beyond H_ACTIVE, which sets the colour-bar width.

Parameters:
- COLOR_W, 4, bits per colour channel.
- H_ACTIVE, 640, visible pixels per line; bar width BAR_W = H_ACTIVE/8, must be an integer.
- CHK_LOG2, 5, checkerboard square size = 2**CHK_LOG2 pixels.
- SOLID_RGB, all-ones (3*COLOR_W bits), colour for mode 0, packed {r,g,b}.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- h_sync  in  1  horizontal sync from timing controller, active low.
- v_sync  in  1  vertical sync from timing controller, active low.
- active  in  1  visible-area flag from timing controller.
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
- vga_hs  out  1  h_sync delayed 2 cycles.
- vga_vs  out  1  v_sync delayed 2 cycles.
- vga_de  out  1  active delayed 2 cycles, qualified by frame lock.
- vga_r / vga_g / vga_b  out  COLOR_W each  pixel colour.
- frame_cnt  out  16  frames started since reset, wraps.

Behaviour:
- Reset (rst=1 at a clk edge): all pipeline registers cleared.
  - vga_hs=1, vga_vs=1, vga_de=0, rgb=0, frame_cnt=0, counters=0, mode latch=0, FSM=WAIT_FRAME.
  - Reset mid-frame is legal: output goes blank until the next frame start.
- Edge detect: registered copies of v_sync and active.
  - frame_start = v_sync_q & ~v_sync (falling edge).
  - line_end = active_q & ~active.
- FSM:
  - WAIT_FRAME -> LOCKED on frame_start.
  - LOCKED stays LOCKED. Returns to WAIT_FRAME only on rst.
  - In WAIT_FRAME, de_qual=0, so vga_de=0 and rgb=0, while vga_hs/vga_vs still pass through delayed.
- On frame_start:
  - y<=0, x<=0.
  - mode_l<=mode; mode changes take effect only at frame boundaries.
  - frame_cnt<=frame_cnt+1, wrapping 65535->0.
- Horizontal counters, 12 bits:
  - x: on active=1, x<=x+1; on active=0, x<=0.
  - Bar counter bar_px (0..BAR_W-1) and bar_idx (0..7) advance with x. At bar_px==BAR_W-1, bar_px<=0 and bar_idx<=bar_idx+1, saturating at 7. Both clear when active=0.
  - No divider is permitted.
- Vertical: y<=y+1 on line_end, saturating at 4095. A simultaneous frame_start takes priority and sets y<=0.
- Pipeline, latency exactly 2 clk from an input to the matching outputs:
  - Stage 1 registers: x, y, bar_idx, de = active & LOCKED, hs, vs.
  - Stage 2 registers: rgb, vga_de, vga_hs, vga_vs.
  - The pixel with input active in cycle n carries coordinate x = number of active cycles before it on that line. It appears on the outputs in cycle n+2.
- Colour, computed from stage-1 values:
  - Mode 0: SOLID_RGB.
  - Mode 1: bar_idx 0..7 -> white, yellow, cyan, green, magenta, red, blue, black. Full channel = all ones, off = 0.
  - Mode 2: x[CHK_LOG2]^y[CHK_LOG2] ? white : black.
  - Mode 3: r=x[COLOR_W+2:3], g=y[COLOR_W+2:3], b=r^g.
  - rgb is forced to 0 whenever stage-1 de=0.

Decomposition:
- Package vga_pkg holds:
  - mode enum (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD);
  - FSM state enum;
  - the 8-entry bar colour constant table;
  - coordinate width constant (12).
- One natural sub-module, vga_pattern_lut: combinational mode/x/y/bar_idx -> rgb. The top level keeps the counters, FSM and pipeline.

Test Plan:
- Reset, then drive sync/active with no v_sync falling edge -> vga_de=0 and rgb=0 throughout; vga_hs follows h_sync delayed by 2 cycles.
- 640x480 timing, mode=1 -> pixel x=0..79 white (F,F,F), x=80 yellow (F,F,0), x=560..639 black. First white appears 2 cycles after the first active of each line.
- mode=2, CHK_LOG2=5 -> (x=0,y=0) white? No: x[5]^y[5]=0 gives black; (x=32,y=0) white; (x=32,y=32) black.
- Switch mode 0->3 mid-frame -> frame continues solid SOLID_RGB; the next frame shows gradient, with (x=8,y=0) giving r=1, g=0, b=1.
- Run 3 frames -> frame_cnt=3; last visible line has y=479; y returns to 0 at each v_sync falling edge.
- Assert rst for 1 cycle mid-line -> next cycle outputs are vga_de=0, rgb=0, hs/vs=1, frame_cnt=0; blank until the next frame_start, then correct pattern from y=0.
